// File: rtl/punc_control.sv
// PUnC LC3 control FSM: fetch/decode/execute sequencing, datapath strobes, retired-instruction count.
// Strobes are combinational from state and IR feedback; optional reserved-opcode trap via PUNC_ILLEGAL_TRAP_EN.
module punc_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic        bitfive,
  input  logic        biteleven,
  input  logic        br_enable,
  input  logic [2:0]  pc_instr,
  output logic        ir_ld,
  output logic        decode,
  output logic [1:0]  extend,
  output logic [1:0]  op1,
  output logic        op2,
  output logic [2:0]  result,
  output logic        rf_w_en,
  output logic [1:0]  pc_select,
  output logic        branch,
  output logic [2:0]  mem_read_loc,
  output logic [1:0]  mem_write_loc,
  output logic        mem_w_en,
  output logic        halted,
  output logic        illegal_op,
  output logic [15:0] instr_count
);

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
`ifdef PUNC_ILLEGAL_TRAP_EN
  localparam logic [3:0] OP_RSV  = 4'b1101;
`endif
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_EXEC2  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t state;

  // IR[8:6] carries no decode information for this controller.
  logic unused_pc_instr;
  assign unused_pc_instr = ^pc_instr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_FETCH;
      instr_count <= 16'd0;
      halted      <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          if (opcode == OP_TRAP) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end
`ifdef PUNC_ILLEGAL_TRAP_EN
          else if (opcode == OP_RSV) begin
            state      <= S_HALT;
            halted     <= 1'b1;
            illegal_op <= 1'b1;
          end
`endif
          else if (opcode == OP_LDI) begin
            state <= S_EXEC2;
          end else begin
            state       <= S_FETCH;
            instr_count <= instr_count + 16'd1;
          end
        end
        S_EXEC2: begin
          state       <= S_FETCH;
          instr_count <= instr_count + 16'd1;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Strobes are gated by rst so nothing reaches the datapath during reset.
  always_comb begin
    ir_ld         = 1'b0;
    decode        = 1'b0;
    extend        = 2'd0;
    op1           = 2'd0;
    op2           = 1'b0;
    result        = 3'd0;
    rf_w_en       = 1'b0;
    pc_select     = 2'd0;
    branch        = 1'b0;
    mem_read_loc  = 3'd0;
    mem_write_loc = 2'd0;
    mem_w_en      = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH:  ir_ld  = 1'b1;
        S_DECODE: decode = 1'b1;
        S_EXEC: begin
          case (opcode)
            OP_ADD, OP_AND: begin
              op1     = 2'd2;
              op2     = bitfive;
              result  = (opcode == OP_ADD) ? 3'd1 : 3'd2;
              rf_w_en = 1'b1;
            end
            OP_NOT: begin
              result  = 3'd3;
              rf_w_en = 1'b1;
            end
            OP_LEA: begin
              op1     = 2'd3;
              op2     = 1'b1;
              extend  = 2'd2;
              result  = 3'd1;
              rf_w_en = 1'b1;
            end
            OP_BR: begin
              if (br_enable) begin
                pc_select = 2'd2;
                extend    = 2'd2;
                branch    = 1'b1;
              end
            end
            OP_JMP: pc_select = 2'd1;
            OP_JSR: begin
              if (biteleven) begin
                pc_select = 2'd2;
                extend    = 2'd3;
              end else begin
                pc_select = 2'd3;
              end
              result  = 3'd5;
              rf_w_en = 1'b1;
            end
            OP_LD: begin
              mem_read_loc = 3'd1;
              extend       = 2'd2;
              result       = 3'd4;
              rf_w_en      = 1'b1;
            end
            OP_LDR: begin
              mem_read_loc = 3'd2;
              extend       = 2'd1;
              result       = 3'd4;
              rf_w_en      = 1'b1;
            end
            OP_LDI: begin
              mem_read_loc = 3'd3;
              extend       = 2'd2;
            end
            OP_ST: begin
              mem_write_loc = 2'd1;
              extend        = 2'd2;
              mem_w_en      = 1'b1;
            end
            OP_STR: begin
              mem_write_loc = 2'd2;
              extend        = 2'd1;
              mem_w_en      = 1'b1;
            end
            OP_STI: begin
              mem_write_loc = 2'd3;
              extend        = 2'd2;
              mem_w_en      = 1'b1;
            end
            default: ;
          endcase
        end
        S_EXEC2: begin
          mem_read_loc = 3'd4;
          result       = 3'd4;
          rf_w_en      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_punc_control.sv
// Randomized instruction stream plus directed cases for punc_control, checked against a mnemonic-level model.
module tb_punc_control;

  typedef struct packed {
    logic       ir_ld;
    logic       decode;
    logic [1:0] extend;
    logic [1:0] op1;
    logic       op2;
    logic [2:0] result;
    logic       rf_w_en;
    logic [1:0] pc_select;
    logic       branch;
    logic [2:0] mem_read_loc;
    logic [1:0] mem_write_loc;
    logic       mem_w_en;
  } strobes_t;

  localparam int PH_FETCH = 0, PH_DECODE = 1, PH_EXEC = 2, PH_EXEC2 = 3, PH_IDLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic        bitfive = 1'b0, biteleven = 1'b0, br_enable = 1'b0;
  logic [2:0]  pc_instr = 3'd0;
  logic        ir_ld, decode, op2, rf_w_en, branch, mem_w_en, halted, illegal_op;
  logic [1:0]  extend, op1, pc_select, mem_write_loc;
  logic [2:0]  result, mem_read_loc;
  logic [15:0] instr_count;
  strobes_t    obs;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  logic exp_halt = 1'b0;
  logic exp_ill = 1'b0;
`ifdef PUNC_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  punc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .bitfive(bitfive), .biteleven(biteleven),
    .br_enable(br_enable), .pc_instr(pc_instr), .ir_ld(ir_ld), .decode(decode),
    .extend(extend), .op1(op1), .op2(op2), .result(result), .rf_w_en(rf_w_en),
    .pc_select(pc_select), .branch(branch), .mem_read_loc(mem_read_loc),
    .mem_write_loc(mem_write_loc), .mem_w_en(mem_w_en), .halted(halted),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign obs = {ir_ld, decode, extend, op1, op2, result, rf_w_en, pc_select, branch,
                mem_read_loc, mem_write_loc, mem_w_en};

  // Expected strobes written straight from the instruction table, one mnemonic per entry.
  function automatic strobes_t model(input int ph, input logic [3:0] op,
                                     input logic b5, input logic b11, input logic bre);
    strobes_t s = '0;
    if (ph == PH_FETCH) s.ir_ld = 1'b1;
    else if (ph == PH_DECODE) s.decode = 1'b1;
    else if (ph == PH_EXEC2) begin s.mem_read_loc = 3'd4; s.result = 3'd4; s.rf_w_en = 1'b1; end
    else if (ph == PH_EXEC) begin
      case (op)
        4'b0001: begin s.op1 = 2; s.op2 = b5; s.result = 1; s.rf_w_en = 1; end
        4'b0101: begin s.op1 = 2; s.op2 = b5; s.result = 2; s.rf_w_en = 1; end
        4'b1001: begin s.result = 3; s.rf_w_en = 1; end
        4'b1110: begin s.op1 = 3; s.op2 = 1; s.extend = 2; s.result = 1; s.rf_w_en = 1; end
        4'b0000: if (bre) begin s.pc_select = 2; s.extend = 2; s.branch = 1; end
        4'b1100: s.pc_select = 1;
        4'b0100: begin
          if (b11) begin s.pc_select = 2; s.extend = 3; end else s.pc_select = 3;
          s.result = 5; s.rf_w_en = 1;
        end
        4'b0010: begin s.mem_read_loc = 1; s.extend = 2; s.result = 4; s.rf_w_en = 1; end
        4'b0110: begin s.mem_read_loc = 2; s.extend = 1; s.result = 4; s.rf_w_en = 1; end
        4'b1010: begin s.mem_read_loc = 3; s.extend = 2; end
        4'b0011: begin s.mem_write_loc = 1; s.extend = 2; s.mem_w_en = 1; end
        4'b0111: begin s.mem_write_loc = 2; s.extend = 1; s.mem_w_en = 1; end
        4'b1011: begin s.mem_write_loc = 3; s.extend = 2; s.mem_w_en = 1; end
        default: ;
      endcase
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".count"}, 32'(instr_count), 32'(exp_cnt));
    chk({tag, ".halted"}, 32'(halted), 32'(exp_halt));
    chk({tag, ".illegal"}, 32'(illegal_op), 32'(exp_ill));
  endtask

  // Starts anywhere inside a FETCH cycle; returns #1 after the edge that ends the instruction.
  task automatic run_instr(input logic [3:0] op, input logic b5, input logic b11, input logic bre);
    string t;
    t = $sformatf("op%b", op);
    opcode = op; bitfive = b5; biteleven = b11; br_enable = bre; pc_instr = 3'($urandom);
    #1 chk({t, ".fetch"}, 32'(obs), 32'(model(PH_FETCH, op, b5, b11, bre)));
    @(posedge clk); #1;
    chk({t, ".decode"}, 32'(obs), 32'(model(PH_DECODE, op, b5, b11, bre)));
    @(posedge clk); #1;
    chk({t, ".exec"}, 32'(obs), 32'(model(PH_EXEC, op, b5, b11, bre)));
    @(posedge clk); #1;
    if (op == 4'b1010) begin
      chk({t, ".exec2"}, 32'(obs), 32'(model(PH_EXEC2, op, b5, b11, bre)));
      @(posedge clk); #1;
    end
    if (op == 4'b1111 || (TRAP_EN && op == 4'b1101)) begin
      exp_halt = 1'b1;
      if (op == 4'b1101) exp_ill = 1'b1;
    end else begin
      exp_cnt = (exp_cnt + 1) % 65536;
    end
    chk_status(t);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    exp_cnt = 0; exp_halt = 1'b0; exp_ill = 1'b0;
    chk("reset.strobes", 32'(obs), 32'(model(PH_IDLE, 4'd0, 1'b0, 1'b0, 1'b0)));
    chk_status("reset");
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
  endtask

  initial begin : main
    logic [3:0] op;
    #3;
    do_reset();

    // Directed: ADD R1,R1,#3 immediate form, count 0 -> 1.
    run_instr(4'b0001, 1'b1, 1'b0, 1'b0);
    // LDI takes four cycles and writes only in EXEC2.
    run_instr(4'b1010, 1'b0, 1'b0, 1'b0);
    // BR not taken, then taken.
    run_instr(4'b0000, 1'b0, 1'b0, 1'b0);
    run_instr(4'b0000, 1'b0, 1'b0, 1'b1);
    // JSR and JSRR.
    run_instr(4'b0100, 1'b0, 1'b1, 1'b0);
    run_instr(4'b0100, 1'b0, 1'b0, 1'b0);

    // Random stream of non-halting instructions.
    for (int i = 0; i < 200; i++) begin
      do op = 4'($urandom_range(0, 15));
      while (op == 4'b1111 || (TRAP_EN && op == 4'b1101));
      run_instr(op, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset pulled mid-EXEC2 of an LDI: strobes drop at once, count clears.
    opcode = 4'b1010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ldi_rst.exec2", 32'(obs), 32'(model(PH_EXEC2, 4'b1010, 1'b0, 1'b0, 1'b0)));
    rst = 1'b0;
    #1 chk("ldi_rst.async_gate", 32'(obs), 32'(model(PH_IDLE, 4'd0, 1'b0, 1'b0, 1'b0)));
    exp_cnt = 0; exp_halt = 1'b0; exp_ill = 1'b0;
    chk_status("ldi_rst");
    @(posedge clk); #3;
    rst = 1'b1;
    #1 chk("ldi_rst.fetch", 32'(obs), 32'(model(PH_FETCH, 4'd0, 1'b0, 1'b0, 1'b0)));
    chk_status("ldi_rst.post");

    run_instr(4'b0011, 1'b0, 1'b0, 1'b0);

    // Reserved opcode: NOP without the trap option, halt with it.
    run_instr(4'b1101, 1'b1, 1'b1, 1'b1);
    if (exp_halt) begin
      repeat (3) begin
        @(posedge clk); #1;
        chk("rsv.halted_strobes", 32'(obs), 32'(model(PH_IDLE, 4'd0, 1'b0, 1'b0, 1'b0)));
      end
      do_reset();
    end
    run_instr(4'b1001, 1'b0, 1'b0, 1'b0);

    // TRAP: halt, strobes stay low for 20 cycles, count frozen.
    run_instr(4'b1111, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      opcode = 4'($urandom); bitfive = 1'($urandom); br_enable = 1'($urandom);
      @(posedge clk); #1;
      chk($sformatf("trap.idle%0d", i), 32'(obs), 32'(model(PH_IDLE, 4'd0, 1'b0, 1'b0, 1'b0)));
      chk_status("trap.idle");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
